branch_predictor: RTL and testbench

//   Fetch-side consumer of the EX branch-resolution interface (branch_flag/branch_pc/branch_to/branch_taken).

---
 rtl/branch_predictor_pkg.sv | 24 ++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_predictor_ras.sv | 60 ++++++
 rtl/branch_predictor.sv | 137 +++++++++++++
 tb/tb_branch_predictor.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared constants, counter encodings and predecode helpers for the branch predictor.
// The optional return-address stack is enabled with the BP_RAS_EN macro.
package branch_predictor_pkg;

    localparam int BP_IDX_W     = 6;
    localparam int BP_TAG_W     = 8;
    localparam int BP_RAS_DEPTH = 4;

    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // x1 (ra) and x5 (t0) are the RISC-V link registers.
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// IF lookup and EX update signals of the branch predictor, grouped as one interface.
interface branch_predictor_if;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_fire;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic        upd_taken;
    logic        upd_uncond;

    modport master (
        output if_pc, if_inst, if_fire,
        output upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
        input  pred_taken, pred_pc
    );

    modport slave (
        input  if_pc, if_inst, if_fire,
        input  upd_valid, upd_pc, upd_target, upd_taken, upd_uncond,
        output pred_taken, pred_pc
    );
endinterface

// File: rtl/branch_predictor_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry, a pop when empty is ignored.
module bp_ras
    import branch_predictor_pkg::*;
#(
    parameter int DEPTH = BP_RAS_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);

    logic [31:0]    mem_q [DEPTH];
    logic [31:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d, pop_ptr;
    logic [PTR_W:0]   count_q, count_d;

    // A pop is applied first so a simultaneous push replaces the popped slot.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        pop_ptr = ptr_q;
        if (pop && (count_q != '0)) begin
            pop_ptr = ptr_q - PTR_ONE;
            count_d = count_q - CNT_ONE;
        end
        ptr_d = pop_ptr;
        if (push) begin
            mem_d[pop_ptr] = push_data;
            ptr_d          = pop_ptr + PTR_ONE;
            if (count_d != FULL)
                count_d = count_d + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top   = mem_q[ptr_q - PTR_ONE];
    assign empty = (count_q == '0);

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; zero-latency lookup for IF, training from EX.
// Define BP_RAS_EN to add return-address-stack prediction for calls/returns predecoded from if_inst.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_W     = BP_IDX_W,
    parameter int TAG_W     = BP_TAG_W,
    parameter int RAS_DEPTH = BP_RAS_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    branch_predictor_if.slave bp
);
    localparam int ENTRIES = 1 << IDX_W;

    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic             uncond_q [ENTRIES];
    logic             uncond_d [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    logic             lk_hit, upd_hit, btb_taken;
    logic [31:0]      pc_plus4;

    assign lk_idx    = bp.if_pc[IDX_W+1:2];
    assign lk_tag    = bp.if_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign upd_idx   = bp.upd_pc[IDX_W+1:2];
    assign upd_tag   = bp.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign upd_hit   = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign btb_taken = lk_hit && (uncond_q[lk_idx] || ctr_q[lk_idx][1]);
    assign pc_plus4  = bp.if_pc + 32'd4;

    // Training: a not-taken miss leaves the table alone, a taken miss claims the slot.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        uncond_d = uncond_q;
        if (bp.upd_valid && rdy) begin
            if (upd_hit && bp.upd_taken) begin
                if (ctr_q[upd_idx] != CTR_ST)
                    ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                target_d[upd_idx] = bp.upd_target;
                uncond_d[upd_idx] = bp.upd_uncond;
            end else if (upd_hit) begin
                if (ctr_q[upd_idx] != CTR_SNT)
                    ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end else if (bp.upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = bp.upd_target;
                uncond_d[upd_idx] = bp.upd_uncond;
                ctr_d[upd_idx]    = CTR_WT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_WNT;
            end
        end else begin
            valid_q <= valid_d;
            ctr_q   <= ctr_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
        uncond_q <= uncond_d;
    end

`ifdef BP_RAS_EN
    logic [4:0]  inst_rd, inst_rs1;
    logic        is_jal, is_jalr, is_call, is_ret;
    logic        ras_push, ras_pop, ras_empty;
    logic [31:0] ras_top;

    assign inst_rd  = bp.if_inst[11:7];
    assign inst_rs1 = bp.if_inst[19:15];
    assign is_jal   = (bp.if_inst[6:0] == OP_JAL);
    assign is_jalr  = (bp.if_inst[6:0] == OP_JALR);
    assign is_call  = (is_jal || is_jalr) && is_link(inst_rd);
    // rd == rs1 (both link) is a plain call; distinct link registers mean pop-then-push.
    assign is_ret   = is_jalr && is_link(inst_rs1) &&
                      ((inst_rd == 5'd0) || (is_link(inst_rd) && (inst_rd != inst_rs1)));
    assign ras_push = is_call && bp.if_fire && rdy && !rst;
    assign ras_pop  = is_ret && bp.if_fire && rdy && !rst;

    bp_ras #(.DEPTH(RAS_DEPTH)) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus4),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{bp.if_inst, bp.if_fire};
`endif

    logic unused_pc;
    assign unused_pc = ^{bp.upd_pc[31:IDX_W+TAG_W+2], bp.upd_pc[1:0]};

    always_comb begin
        bp.pred_taken = 1'b0;
        bp.pred_pc    = pc_plus4;
        if (!rst) begin
            if (btb_taken) begin
                bp.pred_taken = 1'b1;
                bp.pred_pc    = target_q[lk_idx];
            end
`ifdef BP_RAS_EN
            if (is_ret && !ras_empty) begin
                bp.pred_taken = 1'b1;
                bp.pred_pc    = ras_top;
            end
`endif
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor; the RAS section runs only when BP_RAS_EN is defined.
module tb_branch_predictor;

    localparam logic [31:0] INST_NOP  = 32'h00000013;
    localparam logic [31:0] INST_JAL1 = 32'h000000EF;
    localparam logic [31:0] INST_RET  = 32'h00008067;
    localparam logic [31:0] INST_SWAP = 32'h000280E7;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   check_count = 0;
    int   error_count = 0;

    branch_predictor_if bp_if ();

    branch_predictor dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bp  (bp_if)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic checkPred(input string tag, input logic taken, input logic [31:0] pc);
        checkOutput({tag, ".taken"}, {31'd0, bp_if.pred_taken}, {31'd0, taken});
        checkOutput({tag, ".pc"}, bp_if.pred_pc, pc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] inst, input logic fire);
        bp_if.if_pc   = pc;
        bp_if.if_inst = inst;
        bp_if.if_fire = fire;
        #1;
    endtask

    task automatic applyUpdate(input logic [31:0] pc, input logic [31:0] target,
                               input logic taken, input logic uncond);
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = pc;
        bp_if.upd_target = target;
        bp_if.upd_taken  = taken;
        bp_if.upd_uncond = uncond;
        tick();
        bp_if.upd_valid  = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        rdy              = 1'b1;
        bp_if.if_pc      = 32'h100;
        bp_if.if_inst    = INST_NOP;
        bp_if.if_fire    = 1'b0;
        bp_if.upd_valid  = 1'b0;
        bp_if.upd_pc     = '0;
        bp_if.upd_target = '0;
        bp_if.upd_taken  = 1'b0;
        bp_if.upd_uncond = 1'b0;
        #1;
        checkPred("in_reset", 1'b0, 32'h104);
        tick();
        rst = 1'b0;
        applyStimulus(32'h100, INST_NOP, 1'b0);
        checkPred("after_reset", 1'b0, 32'h104);

        // Allocation, counter walk and saturation at both ends.
        applyUpdate(32'h100, 32'h80, 1'b1, 1'b0);
        checkPred("alloc_taken", 1'b1, 32'h80);
        applyUpdate(32'h100, 32'h80, 1'b0, 1'b0);
        checkPred("ctr1", 1'b0, 32'h104);
        applyUpdate(32'h100, 32'h80, 1'b0, 1'b0);
        applyUpdate(32'h100, 32'h80, 1'b0, 1'b0);
        applyUpdate(32'h100, 32'h80, 1'b1, 1'b0);
        checkPred("ctr_min_sat", 1'b0, 32'h104);
        applyUpdate(32'h100, 32'h80, 1'b1, 1'b0);
        checkPred("ctr2_again", 1'b1, 32'h80);
        applyUpdate(32'h100, 32'h80, 1'b1, 1'b0);
        applyUpdate(32'h100, 32'h80, 1'b1, 1'b0);
        applyUpdate(32'h100, 32'h80, 1'b0, 1'b0);
        checkPred("ctr_max_sat", 1'b1, 32'h80);
        applyUpdate(32'h100, 32'h80, 1'b0, 1'b0);
        checkPred("ctr_down_to1", 1'b0, 32'h104);
        applyUpdate(32'h100, 32'h90, 1'b1, 1'b0);
        checkPred("target_retrain", 1'b1, 32'h90);

        // rdy low: lookups still answer, training is frozen.
        rdy = 1'b0;
        #1;
        checkPred("rdy0_lookup", 1'b1, 32'h90);
        applyUpdate(32'h100, 32'h90, 1'b0, 1'b0);
        applyUpdate(32'h100, 32'h90, 1'b0, 1'b0);
        rdy = 1'b1;
        #1;
        checkPred("rdy0_frozen", 1'b1, 32'h90);

        // Alias at the same index with a different tag replaces the entry.
        applyUpdate(32'h200, 32'h40, 1'b1, 1'b0);
        checkPred("alias_old_miss", 1'b0, 32'h104);
        applyStimulus(32'h200, INST_NOP, 1'b0);
        checkPred("alias_new_hit", 1'b1, 32'h40);

        // Same-cycle update and lookup sees pre-edge state.
        doReset();
        applyStimulus(32'h200, INST_NOP, 1'b0);
        bp_if.upd_valid  = 1'b1;
        bp_if.upd_pc     = 32'h200;
        bp_if.upd_target = 32'h44;
        bp_if.upd_taken  = 1'b1;
        bp_if.upd_uncond = 1'b0;
        #1;
        checkPred("same_cycle_miss", 1'b0, 32'h204);
        tick();
        bp_if.upd_valid = 1'b0;
        checkPred("same_cycle_next", 1'b1, 32'h44);

        rdy = 1'b0;
        applyUpdate(32'h700, 32'h10, 1'b1, 1'b0);
        rdy = 1'b1;
        applyStimulus(32'h700, INST_NOP, 1'b0);
        checkPred("rdy0_no_alloc", 1'b0, 32'h704);

        applyUpdate(32'h500, 32'h20, 1'b0, 1'b0);
        applyStimulus(32'h500, INST_NOP, 1'b0);
        checkPred("miss_nt_noalloc", 1'b0, 32'h504);
        applyUpdate(32'h500, 32'h20, 1'b1, 1'b0);
        applyUpdate(32'h500, 32'h20, 1'b0, 1'b0);
        checkPred("alloc_ctr_is2", 1'b0, 32'h504);

        // Unconditional entries predict taken regardless of the counter.
        applyUpdate(32'h800, 32'h900, 1'b1, 1'b1);
        applyUpdate(32'h800, 32'h900, 1'b0, 1'b1);
        applyUpdate(32'h800, 32'h900, 1'b0, 1'b1);
        applyStimulus(32'h800, INST_NOP, 1'b0);
        checkPred("uncond_taken", 1'b1, 32'h900);

        rst = 1'b1;
        #1;
        checkPred("rst_forces_nt", 1'b0, 32'h804);
        tick();
        rst = 1'b0;
        #1;
        checkPred("rst_clears", 1'b0, 32'h804);

        applyStimulus(32'hFFFF_FFFC, INST_NOP, 1'b0);
        checkPred("pc_wrap", 1'b0, 32'h0);

`ifdef BP_RAS_EN
        doReset();
        applyStimulus(32'h300, INST_JAL1, 1'b1);
        tick();
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("ras_ret", 1'b1, 32'h304);
        tick();
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("ras_empty_fallback", 1'b0, 32'h404);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h1000 + 32'(i * 4), INST_JAL1, 1'b1);
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(32'h400, INST_RET, 1'b1);
            checkPred($sformatf("ras_pop%0d", i), 1'b1, 32'h1014 - 32'(i * 4));
            tick();
        end
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("ras_overflow_fallback", 1'b0, 32'h404);
        tick();

        applyStimulus(32'h300, INST_JAL1, 1'b1);
        tick();
        applyStimulus(32'h500, INST_SWAP, 1'b1);
        checkPred("ras_swap_pop", 1'b1, 32'h304);
        tick();
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("ras_swap_push", 1'b1, 32'h504);
        tick();
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("ras_swap_empty", 1'b0, 32'h404);
        tick();
`else
        doReset();
        applyStimulus(32'h300, INST_JAL1, 1'b1);
        tick();
        applyStimulus(32'h400, INST_RET, 1'b1);
        checkPred("no_ras_ignores_inst", 1'b0, 32'h404);
        tick();
`endif
        bp_if.if_fire = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
